// File: rtl/stage_queue_if.sv
// Valid/ready handshake bundle between a producer/consumer pair and stage_queue.
// The queue takes the slave view; the environment driving it takes the master view.
interface stage_queue_if #(
   parameter int WIDTH = 96
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/stage_queue.sv
// First-word-fall-through decoupling queue between pipeline stages, with flush,
// occupancy/almost-full status and sticky overflow/underflow flags.
module stage_queue #(
   parameter int WIDTH     = 96,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   stage_queue_if.slave               q,
   input  logic                       flush_i,
   input  logic                       err_clear_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       almost_full_o,
   output logic                       empty_o,
   output logic                       err_overflow_o,
   output logic                       err_underflow_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_overflow_q, err_overflow_d;
   logic             err_underflow_q, err_underflow_d;

   logic in_ready;
   logic out_valid;
   logic push;
   logic pop;

   // Handshake status decodes registered occupancy only, never the live inputs.
   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);

   assign push = q.in_valid & in_ready & ~flush_i;
   assign pop  = out_valid & q.out_ready & ~flush_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
         end
         if (pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // A new violation in the same cycle as err_clear keeps the flag set.
   always_comb begin
      err_overflow_d  = err_overflow_q & ~err_clear_i;
      err_underflow_d = err_underflow_q & ~err_clear_i;
      if (q.in_valid & ~in_ready) begin
         err_overflow_d = 1'b1;
      end
      if (q.out_ready & ~out_valid) begin
         err_underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         err_overflow_q  <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         err_overflow_q  <= err_overflow_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (tail_q == PW'(gi))) begin
               mem_q[gi] <= q.in_data;
            end
         end
      end
   endgenerate

   assign q.in_ready  = in_ready;
   assign q.out_valid = out_valid;
   assign q.out_data  = out_valid ? mem_q[head_q] : '0;

   assign count_o         = count_q;
   assign almost_full_o   = (count_q >= AF_CNT);
   assign empty_o         = (count_q == '0);
   assign err_overflow_o  = err_overflow_q;
   assign err_underflow_o = err_underflow_q;
endmodule

// File: tb/tb_stage_queue.sv
// Directed bench for stage_queue at DEPTH=5, WIDTH=8, AF_THRESH=4: a per-cycle
// vector table plus hand-written wrap-around and asynchronous-reset sequences.
module tb_stage_queue;
   localparam int WIDTH = 8;
   localparam int DEPTH = 5;
   localparam int AF    = 4;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       fl;
      logic       ec;
      logic [2:0] cnt;
      logic       ov;
      logic [7:0] od;
      logic       ir;
      logic       af;
      logic       em;
      logic       eo;
      logic       eu;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       err_clear = 1'b0;
   logic [2:0] count;
   logic       almost_full, empty, err_ov, err_un;

   int n_cmp = 0;
   int n_bad = 0;

   stage_queue_if #(.WIDTH(WIDTH)) bus ();

   stage_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
      .clk             (clk),
      .rst             (rst),
      .q               (bus.slave),
      .flush_i         (flush),
      .err_clear_i     (err_clear),
      .count_o         (count),
      .almost_full_o   (almost_full),
      .empty_o         (empty),
      .err_overflow_o  (err_ov),
      .err_underflow_o (err_un)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                        input logic fl, input logic ec);
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      flush         = fl;
      err_clear     = ec;
   endtask

   task automatic chk_status(input string tag, input logic [2:0] c, input logic ov,
                             input logic [7:0] od, input logic ir, input logic af,
                             input logic em, input logic eo, input logic eu);
      chk({tag, "_count"}, 32'(count), 32'(c));
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
      chk({tag, "_out_data"}, 32'(bus.out_data), 32'(od));
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(ir));
      chk({tag, "_almost_full"}, 32'(almost_full), 32'(af));
      chk({tag, "_empty"}, 32'(empty), 32'(em));
      chk({tag, "_err_overflow"}, 32'(err_ov), 32'(eo));
      chk({tag, "_err_underflow"}, 32'(err_un), 32'(eu));
   endtask

   vec_t       vecs [18];
   logic [7:0] mq [$];
   logic [7:0] v;

   initial begin
      //            iv  id     ordy fl ec   cnt ov od     ir af em eo eu
      vecs[0]  = '{1, 8'h11, 0, 0, 0,  1, 1, 8'h11, 1, 0, 0, 0, 0};
      vecs[1]  = '{1, 8'h12, 0, 0, 0,  2, 1, 8'h11, 1, 0, 0, 0, 0};
      vecs[2]  = '{1, 8'h13, 0, 0, 0,  3, 1, 8'h11, 1, 0, 0, 0, 0};
      vecs[3]  = '{1, 8'h14, 0, 0, 0,  4, 1, 8'h11, 1, 1, 0, 0, 0};
      vecs[4]  = '{1, 8'h15, 0, 0, 0,  5, 1, 8'h11, 0, 1, 0, 0, 0};
      vecs[5]  = '{1, 8'h66, 1, 0, 0,  4, 1, 8'h12, 1, 1, 0, 1, 0}; // full: pop ok, push refused
      vecs[6]  = '{0, 8'h00, 0, 0, 1,  4, 1, 8'h12, 1, 1, 0, 0, 0};
      vecs[7]  = '{0, 8'h00, 1, 0, 0,  3, 1, 8'h13, 1, 0, 0, 0, 0};
      vecs[8]  = '{0, 8'h00, 1, 0, 0,  2, 1, 8'h14, 1, 0, 0, 0, 0};
      vecs[9]  = '{0, 8'h00, 1, 0, 0,  1, 1, 8'h15, 1, 0, 0, 0, 0};
      vecs[10] = '{0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 1, 0, 1, 0, 0};
      vecs[11] = '{1, 8'hA5, 1, 0, 0,  1, 1, 8'hA5, 1, 0, 0, 0, 1}; // push into empty + underflow
      vecs[12] = '{1, 8'h21, 0, 0, 0,  2, 1, 8'hA5, 1, 0, 0, 0, 1};
      vecs[13] = '{1, 8'h22, 0, 0, 0,  3, 1, 8'hA5, 1, 0, 0, 0, 1};
      vecs[14] = '{1, 8'h77, 1, 1, 0,  0, 0, 8'h00, 1, 0, 1, 0, 1}; // flush beats push/pop
      vecs[15] = '{0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 1, 0, 1, 0, 0};
      vecs[16] = '{0, 8'h00, 1, 0, 1,  0, 0, 8'h00, 1, 0, 1, 0, 1}; // set wins over clear
      vecs[17] = '{1, 8'h31, 0, 0, 0,  1, 1, 8'h31, 1, 0, 0, 0, 1};

      drive(0, 8'h00, 0, 0, 0);
      #2;
      chk_status("reset", 0, 0, 8'h00, 1, 0, 1, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].ec);
         @(posedge clk);
         #1;
         $display("vec %0d: count=%0d out_valid=%0b out_data=%02h in_ready=%0b err=%0b%0b",
                  i, count, bus.out_valid, bus.out_data, bus.in_ready, err_ov, err_un);
         chk_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].od, vecs[i].ir,
                    vecs[i].af, vecs[i].em, vecs[i].eo, vecs[i].eu);
      end

      // Streaming at count=2: pointers wrap twice, order must match push order.
      drive(1, 8'h32, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("t3_prefill_count", 32'(count), 32'd2);
      mq = {8'h31, 8'h32};
      for (int i = 0; i < 12; i++) begin
         v = 8'h40 + 8'(i);
         chk($sformatf("t3_head%0d", i), 32'(bus.out_data), 32'(mq[0]));
         drive(1, v, 1, 0, 0);
         @(posedge clk);
         #1;
         void'(mq.pop_front());
         mq.push_back(v);
         $display("stream %0d: pushed %02h count=%0d head=%02h", i, v, count, bus.out_data);
         chk($sformatf("t3_count%0d", i), 32'(count), 32'd2);
      end
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("t3_drain%0d", i), 32'(bus.out_data), 32'(mq[0]));
         drive(0, 8'h00, 1, 0, 0);
         @(posedge clk);
         #1;
         void'(mq.pop_front());
      end
      chk("t3_empty", 32'(empty), 32'd1);

      // Asynchronous reset between edges at count=3.
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'h51 + 8'(i), 0, 0, 0);
         @(posedge clk);
         #1;
      end
      drive(0, 8'h00, 0, 0, 0);
      chk("t6_pre_count", 32'(count), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      $display("async reset: count=%0d out_valid=%0b in_ready=%0b", count, bus.out_valid, bus.in_ready);
      chk_status("t6_async", 0, 0, 8'h00, 1, 0, 1, 0, 0);
      @(posedge clk);
      #1;
      chk("t6_held_count", 32'(count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 8'h99, 0, 0, 0);
      #1;
      chk("t6_no_bypass", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      drive(0, 8'h00, 0, 0, 0);
      $display("post reset push: count=%0d out_data=%02h", count, bus.out_data);
      chk("t6_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t6_out_data", 32'(bus.out_data), 32'h99);
      chk("t6_count", 32'(count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
